jlsemi_util_clkdiv_cfg_ctrl: RTL and testbench



---
 rtl/jlsemi_clkdiv_cfg_pkg.sv | 48 ++++
 rtl/jlsemi_util_clkdiv_cfg_check.sv | 27 ++
 rtl/jlsemi_util_clkdiv_cfg_ctrl.sv | 162 ++++++++++++++++
 tb/tb_jlsemi_util_clkdiv_cfg_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/jlsemi_clkdiv_cfg_pkg.sv
// Shared types, widths and helpers for the clock-divider configuration sequencer.
// Build option: JLSEMI_CLKDIV_CFG_AUTO_ROUND_EN (consumed by jlsemi_util_clkdiv_cfg_check).
package jlsemi_clkdiv_cfg_pkg;

    localparam int DIV_W = 9;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        HOLD    = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } cfg_state_e;

    typedef struct packed {
        logic             valid;
        logic [DIV_W-1:0] div_n;
    } cfg_chk_t;

    // Odd ratios are optionally rounded down first; the phase is checked against the final ratio.
    function automatic cfg_chk_t cfg_validate(
        input logic [DIV_W-1:0] div_n,
        input logic [DIV_W-1:0] phase,
        input logic             round_en
    );
        cfg_chk_t         res;
        logic [DIV_W-1:0] n;
        n = div_n;
        if (round_en && div_n[0] && (div_n >= 9'd3)) begin
            n[0] = 1'b0;
        end else begin
            n = div_n;
        end
        res.div_n = n;
        res.valid = (n[0] == 1'b0) && (n >= 9'd2) && (phase < {1'b0, n[DIV_W-1:1]});
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == {CNT_W{1'b1}}) begin
            return cnt;
        end else begin
            return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/jlsemi_util_clkdiv_cfg_check.sv
// Combinational validator/rounder for a requested divide ratio and phase.
// Build option: JLSEMI_CLKDIV_CFG_AUTO_ROUND_EN rounds odd ratios >= 3 down to even.
module jlsemi_util_clkdiv_cfg_check
    import jlsemi_clkdiv_cfg_pkg::*;
(
    input  logic [DIV_W-1:0] div_n,
    input  logic [DIV_W-1:0] phase,
    output logic             valid,
    output logic [DIV_W-1:0] div_n_rnd
);

`ifdef JLSEMI_CLKDIV_CFG_AUTO_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    cfg_chk_t chk_s;

    // Evaluate the request through the shared validation rule
    always_comb begin
        chk_s     = cfg_validate(div_n, phase, ROUND_EN);
        valid     = chk_s.valid;
        div_n_rnd = chk_s.div_n;
    end

endmodule

// File: rtl/jlsemi_util_clkdiv_cfg_ctrl.sv
// Glitch-free configuration sequencer for the even clock divider: validate, hold reset, switch, release, ack.
// Build option: JLSEMI_CLKDIV_CFG_AUTO_ROUND_EN (odd-ratio rounding inside the checker).
module jlsemi_util_clkdiv_cfg_ctrl
    import jlsemi_clkdiv_cfg_pkg::*;
#(
    parameter logic [DIV_W-1:0] DEF_DIV_N      = 9'd4,
    parameter logic [DIV_W-1:0] DEF_PHASE      = 9'd0,
    parameter int               RST_HOLD_CYC   = 8,
    parameter int               RST_SYNC_STAGE = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [DIV_W-1:0] cfg_div_n,
    input  logic [DIV_W-1:0] cfg_phase,
    input  logic             cfg_upd_req,
    output logic             cfg_upd_ack,
    output logic             cfg_busy,
    output logic             cfg_err,
    output logic             cfg_err_sticky,
    output logic [DIV_W-1:0] div_n_o,
    output logic [DIV_W-1:0] div_phase_o,
    output logic             div_rstn_o
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RST_SYNC_STAGE + 1);
    // Ratio switches one cycle after reset is driven low, so the divider never sees it live.
    localparam logic [CNT_W-1:0] LOAD_CNT  = (RST_HOLD_CYC > 1) ? 8'd1 : 8'd0;

    cfg_state_e       state_r;
    cfg_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             pwrup_r;
    logic [DIV_W-1:0] shd_div_n_r;
    logic [DIV_W-1:0] shd_phase_r;
    logic             chk_valid_s;
    logic [DIV_W-1:0] chk_div_n_s;

    logic             ack_r;
    logic             busy_r;
    logic             err_r;
    logic             sticky_r;
    logic [DIV_W-1:0] div_n_r;
    logic [DIV_W-1:0] div_phase_r;
    logic             div_rstn_r;

    jlsemi_util_clkdiv_cfg_check u_check (
        .div_n     (shd_div_n_r),
        .phase     (shd_phase_r),
        .valid     (chk_valid_s),
        .div_n_rnd (chk_div_n_s)
    );

    // Next-state and hold/release counter logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (cfg_upd_req) begin
                    state_nxt_s = CHECK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CHECK: begin
                cnt_nxt_s = {CNT_W{1'b0}};
                if (chk_valid_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if (cnt_r >= HOLD_LAST) begin
                    state_nxt_s = RELEASE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s   = cnt_sat_inc(cnt_r);
                end
            end
            RELEASE: begin
                if (cnt_r >= REL_LAST) begin
                    // The power-up pass finishes silently; only requested updates are acknowledged.
                    if (pwrup_r) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DONE;
                    end
                    cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_sat_inc(cnt_r);
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = HOLD;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, power-up flag and shadow request registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r     <= HOLD;
            cnt_r       <= {CNT_W{1'b0}};
            pwrup_r     <= 1'b1;
            shd_div_n_r <= DEF_DIV_N;
            shd_phase_r <= DEF_PHASE;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if ((state_r == RELEASE) && (state_nxt_s != RELEASE)) begin
                pwrup_r <= 1'b0;
            end
            if ((state_r == IDLE) && cfg_upd_req) begin
                shd_div_n_r <= cfg_div_n;
                shd_phase_r <= cfg_phase;
            end else if ((state_r == CHECK) && chk_valid_s) begin
                shd_div_n_r <= chk_div_n_s;
            end
        end
    end

    // Registered outputs derived from the current state
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ack_r       <= 1'b0;
            busy_r      <= 1'b1;
            err_r       <= 1'b0;
            sticky_r    <= 1'b0;
            div_n_r     <= DEF_DIV_N;
            div_phase_r <= DEF_PHASE;
            div_rstn_r  <= 1'b0;
        end else begin
            ack_r      <= (state_r == DONE);
            busy_r     <= (state_r != IDLE);
            err_r      <= (state_r == CHECK) && !chk_valid_s;
            div_rstn_r <= (state_r != HOLD);
            if (state_r == CHECK) begin
                sticky_r <= !chk_valid_s;
            end
            if ((state_r == HOLD) && (cnt_r == LOAD_CNT)) begin
                div_n_r     <= shd_div_n_r;
                div_phase_r <= shd_phase_r;
            end
        end
    end

    assign cfg_upd_ack    = ack_r;
    assign cfg_busy       = busy_r;
    assign cfg_err        = err_r;
    assign cfg_err_sticky = sticky_r;
    assign div_n_o        = div_n_r;
    assign div_phase_o    = div_phase_r;
    assign div_rstn_o     = div_rstn_r;

endmodule

// File: tb/tb_jlsemi_util_clkdiv_cfg_ctrl.sv
// Directed bench for the clock-divider configuration sequencer (default parameters).
module tb_jlsemi_util_clkdiv_cfg_ctrl;

    logic       clk_in;
    logic       rst_in;
    logic [8:0] cfg_div_n;
    logic [8:0] cfg_phase;
    logic       cfg_upd_req;
    logic       cfg_upd_ack;
    logic       cfg_busy;
    logic       cfg_err;
    logic       cfg_err_sticky;
    logic [8:0] div_n_o;
    logic [8:0] div_phase_o;
    logic       div_rstn_o;

    int n_cmp;
    int n_bad;
    int cyc;
    logic [8:0] cur_n;
    logic [8:0] cur_ph;

    typedef struct {
        logic [8:0] n;
        logic [8:0] ph;
        bit         err;
        logic [8:0] en;
        logic [8:0] eph;
    } vec_t;

    vec_t tbl [11];

    jlsemi_util_clkdiv_cfg_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .cfg_div_n      (cfg_div_n),
        .cfg_phase      (cfg_phase),
        .cfg_upd_req    (cfg_upd_req),
        .cfg_upd_ack    (cfg_upd_ack),
        .cfg_busy       (cfg_busy),
        .cfg_err        (cfg_err),
        .cfg_err_sticky (cfg_err_sticky),
        .div_n_o        (div_n_o),
        .div_phase_o    (div_phase_o),
        .div_rstn_o     (div_rstn_o)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input int c, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, act, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_div_n", 0, int'(div_n_o), 4);
        chk("rst_phase", 0, int'(div_phase_o), 0);
        chk("rst_rstn", 0, int'(div_rstn_o), 0);
        chk("rst_busy", 0, int'(cfg_busy), 1);
        chk("rst_ack", 0, int'(cfg_upd_ack), 0);
        chk("rst_err", 0, int'(cfg_err), 0);
        chk("rst_sticky", 0, int'(cfg_err_sticky), 0);
    endtask

    // Cycle 0 is the first clock edge that samples rst_in low.
    task automatic pwrup_check();
        for (int c = 0; c <= 16; c++) begin
            tick();
            chk("pu_rstn", c, int'(div_rstn_o), int'(c >= 8));
            chk("pu_busy", c, int'(cfg_busy), int'(c <= 12));
            chk("pu_ack", c, int'(cfg_upd_ack), 0);
            chk("pu_div_n", c, int'(div_n_o), 4);
        end
        cur_n  = 9'd4;
        cur_ph = 9'd0;
    endtask

    // Request sampled at cycle 0; optional second request raised at view cycle intr.
    task automatic run_req(input logic [8:0] n, input logic [8:0] ph, input bit exp_err,
                           input logic [8:0] en, input logic [8:0] eph, input int intr);
        int acks;
        logic [8:0] old_n;
        logic [8:0] old_ph;
        acks   = 0;
        old_n  = cur_n;
        old_ph = cur_ph;
        cfg_div_n   = n;
        cfg_phase   = ph;
        cfg_upd_req = 1'b1;
        tick();
        cfg_upd_req = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if ((intr > 0) && (c - 1 == intr)) begin
                cfg_div_n   = 9'd6;
                cfg_phase   = 9'd2;
                cfg_upd_req = 1'b1;
            end
            tick();
            cfg_upd_req = 1'b0;
            acks += int'(cfg_upd_ack);
            if (c == 1) begin
                chk("err", c, int'(cfg_err), int'(exp_err));
                chk("sticky", c, int'(cfg_err_sticky), int'(exp_err));
            end else begin
                chk("err_idle", c, int'(cfg_err), 0);
            end
            if (exp_err) begin
                chk("bad_busy", c, int'(cfg_busy), int'(c == 1));
                chk("bad_rstn", c, int'(div_rstn_o), 1);
                chk("bad_div_n", c, int'(div_n_o), int'(old_n));
                chk("bad_phase", c, int'(div_phase_o), int'(old_ph));
                chk("bad_ack", c, int'(cfg_upd_ack), 0);
            end else begin
                chk("rstn", c, int'(div_rstn_o), int'((c < 2) || (c > 9)));
                chk("busy", c, int'(cfg_busy), int'(c <= 15));
                chk("ack", c, int'(cfg_upd_ack), int'(c == 15));
                chk("div_n", c, int'(div_n_o), (c >= 3) ? int'(en) : int'(old_n));
                chk("phase", c, int'(div_phase_o), (c >= 3) ? int'(eph) : int'(old_ph));
            end
        end
        chk("ack_count", 20, acks, exp_err ? 0 : 1);
        if (!exp_err) begin
            cur_n  = en;
            cur_ph = eph;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        cur_n  = 9'd4;
        cur_ph = 9'd0;

        tbl[0]  = '{n: 9'd10,  ph: 9'd3,   err: 1'b0, en: 9'd10,  eph: 9'd3};
        tbl[1]  = '{n: 9'd8,   ph: 9'd4,   err: 1'b1, en: 9'd0,   eph: 9'd0};
        tbl[2]  = '{n: 9'd8,   ph: 9'd3,   err: 1'b0, en: 9'd8,   eph: 9'd3};
`ifdef JLSEMI_CLKDIV_CFG_AUTO_ROUND_EN
        tbl[3]  = '{n: 9'd7,   ph: 9'd1,   err: 1'b0, en: 9'd6,   eph: 9'd1};
        tbl[9]  = '{n: 9'd511, ph: 9'd0,   err: 1'b0, en: 9'd510, eph: 9'd0};
`else
        tbl[3]  = '{n: 9'd7,   ph: 9'd1,   err: 1'b1, en: 9'd0,   eph: 9'd0};
        tbl[9]  = '{n: 9'd511, ph: 9'd0,   err: 1'b1, en: 9'd0,   eph: 9'd0};
`endif
        tbl[4]  = '{n: 9'd2,   ph: 9'd0,   err: 1'b0, en: 9'd2,   eph: 9'd0};
        tbl[5]  = '{n: 9'd0,   ph: 9'd0,   err: 1'b1, en: 9'd0,   eph: 9'd0};
        tbl[6]  = '{n: 9'd1,   ph: 9'd0,   err: 1'b1, en: 9'd0,   eph: 9'd0};
        tbl[7]  = '{n: 9'd2,   ph: 9'd1,   err: 1'b1, en: 9'd0,   eph: 9'd0};
        tbl[8]  = '{n: 9'd510, ph: 9'd254, err: 1'b0, en: 9'd510, eph: 9'd254};
        tbl[10] = '{n: 9'd4,   ph: 9'd1,   err: 1'b0, en: 9'd4,   eph: 9'd1};

        rst_in      = 1'b1;
        cfg_div_n   = 9'd0;
        cfg_phase   = 9'd0;
        cfg_upd_req = 1'b0;
        tick();
        tick();
        tick();
        chk_reset_vals();
        rst_in = 1'b0;
        pwrup_check();

        for (int i = 0; i < 11; i++) begin
            run_req(tbl[i].n, tbl[i].ph, tbl[i].err, tbl[i].en, tbl[i].eph, 0);
        end

        // Requests while busy (mid-HOLD and during the DONE cycle) must be dropped.
        run_req(9'd12, 9'd5, 1'b0, 9'd12, 9'd5, 5);
        run_req(9'd14, 9'd6, 1'b0, 9'd14, 9'd6, 14);

        // Reset in the middle of HOLD aborts back to defaults and reruns power-up.
        cfg_div_n   = 9'd10;
        cfg_phase   = 9'd3;
        cfg_upd_req = 1'b1;
        tick();
        cfg_upd_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
        end
        chk("mid_div_n", 4, int'(div_n_o), 10);
        chk("mid_rstn", 4, int'(div_rstn_o), 0);
        rst_in = 1'b1;
        tick();
        chk_reset_vals();
        rst_in = 1'b0;
        pwrup_check();

        run_req(9'd6, 9'd2, 1'b0, 9'd6, 9'd2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
